// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter: grants one car at a time through a shared door and tracks a 4-spot occupancy map.
// Optional open-door watchdog enabled by defining PARK_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | door shut, arbitrating between entry and exit requests
// IN_OPEN  | door open for an entering car, waiting for car_pass
// OUT_OPEN | door open for an exiting car, waiting for car_pass
// CLOSING  | door shut guard interval before the next grant
module parking_gate_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned CLOSE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enter_req,
    input  logic       exit_req,
    input  logic [1:0] exit_spot,
    input  logic       car_pass,
    output logic       grant_enter,
    output logic       grant_exit,
    output logic       door_open,
    output logic [1:0] assigned_spot,
    output logic [3:0] F,
    output logic [2:0] capacity,
    output logic       full,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_OPEN  = 2'd1,
        OUT_OPEN = 2'd2,
        CLOSING  = 2'd3
    } state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(CLOSE_CYCLES - 1);

    if (CLOSE_CYCLES < 1 || CLOSE_CYCLES > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("parking_gate_arbiter: CLOSE_CYCLES must be 1..15 and TIMEOUT at least 1");
    end

    state_t     state_q, state_d;
    logic [3:0] f_q, f_d;
    logic [1:0] assigned_spot_q, assigned_spot_d;
    logic [1:0] exit_spot_q, exit_spot_d;
    logic       last_entry_q, last_entry_d;
    logic [3:0] guard_q, guard_d;

    logic       idle;
    logic       open_state;
    logic       entry_valid;
    logic       exit_valid;
    logic       pick_entry;
    logic       pick_exit;
    logic       force_close;
    logic       close_now;
    logic [1:0] free_spot;
    logic       full_w;

    assign idle        = (state_q == IDLE);
    assign open_state  = (state_q == IN_OPEN) || (state_q == OUT_OPEN);
    assign full_w      = &f_q;
    assign entry_valid = idle && enter_req && !full_w;
    assign exit_valid  = idle && exit_req && f_q[exit_spot];
    // On a tie the side that was not served last wins.
    assign pick_entry  = entry_valid && (!exit_valid || !last_entry_q);
    assign pick_exit   = exit_valid && !pick_entry;
    assign close_now   = open_state && (car_pass || force_close);

    always_comb begin : free_spot_enc
        free_spot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!f_q[i]) free_spot = 2'(i);
        end
    end

`ifdef PARK_TIMEOUT_EN
    localparam int unsigned    TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_err_q;

    assign force_close = open_state && !car_pass && (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        if (pick_entry || pick_exit) begin
            tmo_d = TMO_LOAD;
        end else if (open_state && (tmo_q != '0)) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= force_close;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign force_close = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_entry) begin
                    state_d = IN_OPEN;
                end else if (pick_exit) begin
                    state_d = OUT_OPEN;
                end
            end
            IN_OPEN, OUT_OPEN: begin
                if (close_now) state_d = CLOSING;
            end
            CLOSING: begin
                if (guard_q == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        grant_enter   = pick_entry;
        grant_exit    = pick_exit;
        door_open     = open_state;
        assigned_spot = assigned_spot_q;
        F             = f_q;
        full          = full_w;
        capacity      = 3'd4 - 3'($countones(f_q));
    end

    always_comb begin
        f_d             = f_q;
        assigned_spot_d = assigned_spot_q;
        exit_spot_d     = exit_spot_q;
        last_entry_d    = last_entry_q;
        guard_d         = guard_q;

        if (pick_entry) begin
            assigned_spot_d = free_spot;
            last_entry_d    = 1'b1;
        end
        if (pick_exit) begin
            exit_spot_d  = exit_spot;
            last_entry_d = 1'b0;
        end

        if ((state_q == IN_OPEN) && car_pass) begin
            f_d[assigned_spot_q] = 1'b1;
        end
        if ((state_q == OUT_OPEN) && car_pass) begin
            f_d[exit_spot_q] = 1'b0;
        end

        if (close_now) begin
            guard_d = GUARD_LOAD;
        end else if ((state_q == CLOSING) && (guard_q != 4'd0)) begin
            guard_d = guard_q - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            f_q             <= 4'b0000;
            assigned_spot_q <= 2'd0;
            exit_spot_q     <= 2'd0;
            last_entry_q    <= 1'b0;
            guard_q         <= 4'd0;
        end else begin
            f_q             <= f_d;
            assigned_spot_q <= assigned_spot_d;
            exit_spot_q     <= exit_spot_d;
            last_entry_q    <= last_entry_d;
            guard_q         <= guard_d;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level occupancy model.
module tb_parking_gate_arbiter;

    localparam int TIMEOUT      = 16;
    localparam int CLOSE_CYCLES = 2;

    logic       CLK;
    logic       RST;
    logic       enter_req;
    logic       exit_req;
    logic [1:0] exit_spot;
    logic       car_pass;
    logic       grant_enter;
    logic       grant_exit;
    logic       door_open;
    logic [1:0] assigned_spot;
    logic [3:0] F;
    logic [2:0] capacity;
    logic       full;
    logic       timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: occupancy map and which side was served last (1 = entry).
    logic [3:0] m_f;
    logic       m_last_entry;

    parking_gate_arbiter #(
        .TIMEOUT      (TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .enter_req     (enter_req),
        .exit_req      (exit_req),
        .exit_spot     (exit_spot),
        .car_pass      (car_pass),
        .grant_enter   (grant_enter),
        .grant_exit    (grant_exit),
        .door_open     (door_open),
        .assigned_spot (assigned_spot),
        .F             (F),
        .capacity      (capacity),
        .full          (full),
        .timeout_err   (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] lowest_free(input logic [3:0] f);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!f[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk_map(input string tag);
        chk({tag, ":F"}, 32'(F), 32'(m_f));
        chk({tag, ":capacity"}, 32'(capacity), 32'(4 - $countones(m_f)));
        chk({tag, ":full"}, 32'(full), 32'(m_f == 4'hF));
    endtask

    // One request round starting in the first IDLE cycle; returns in the next first IDLE cycle.
    task automatic serve(input bit want_in, input bit want_out, input logic [1:0] xspot,
                         input int delay, input string tag);
        bit         in_ok, out_ok, take_in;
        logic [1:0] spot;
        in_ok  = want_in && (m_f != 4'hF);
        out_ok = want_out && m_f[xspot];
        spot   = lowest_free(m_f);
        enter_req = want_in;
        exit_req  = want_out;
        exit_spot = xspot;
        #1;
        if (!in_ok && !out_ok) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, ":no_grant"}, 32'({grant_enter, grant_exit}), 32'(2'b00));
                chk({tag, ":door_shut"}, 32'(door_open), 32'(1'b0));
                tick();
            end
            chk_map({tag, ":idle_map"});
            enter_req = 1'b0;
            exit_req  = 1'b0;
            return;
        end
        take_in = in_ok && (!out_ok || !m_last_entry);
        chk({tag, ":grant"}, 32'({grant_enter, grant_exit}), 32'({take_in, !take_in}));
        tick();
        if (take_in) begin
            enter_req    = 1'b0;
            m_last_entry = 1'b1;
            chk({tag, ":assigned_spot"}, 32'(assigned_spot), 32'(spot));
        end else begin
            exit_req     = 1'b0;
            m_last_entry = 1'b0;
        end
        chk({tag, ":door_open"}, 32'(door_open), 32'(1'b1));
        chk({tag, ":grant_done"}, 32'({grant_enter, grant_exit}), 32'(2'b00));
        repeat (delay) begin
            tick();
            chk({tag, ":door_held"}, 32'(door_open), 32'(1'b1));
            chk({tag, ":F_held"}, 32'(F), 32'(m_f));
        end
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;
        if (take_in) m_f[spot] = 1'b1;
        else         m_f[xspot] = 1'b0;
        chk({tag, ":closing_door"}, 32'(door_open), 32'(1'b0));
        chk_map({tag, ":after_pass"});
        // Requests raised while closing must be ignored.
        enter_req = 1'b1;
        car_pass  = 1'b1;
        #1;
        for (int i = 1; i < CLOSE_CYCLES; i++) begin
            chk({tag, ":closing_no_grant"}, 32'({grant_enter, grant_exit}), 32'(2'b00));
            tick();
            chk({tag, ":closing_shut"}, 32'(door_open), 32'(1'b0));
        end
        chk({tag, ":closing_last_no_grant"}, 32'({grant_enter, grant_exit}), 32'(2'b00));
        tick();
        car_pass = 1'b0;
        chk({tag, ":closing_F"}, 32'(F), 32'(m_f));
    endtask

    initial begin
        logic [1:0] spot;
        RST       = 1'b1;
        enter_req = 1'b0;
        exit_req  = 1'b0;
        exit_spot = 2'd0;
        car_pass  = 1'b0;
        m_f          = 4'b0000;
        m_last_entry = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst:grants", 32'({grant_enter, grant_exit}), 32'(2'b00));
        chk("rst:door", 32'(door_open), 32'(1'b0));
        chk("rst:timeout_err", 32'(timeout_err), 32'(1'b0));
        chk("rst:assigned_spot", 32'(assigned_spot), 32'(2'd0));
        chk_map("rst");

        serve(1'b0, 1'b1, 2'd1, 1, "exit_free_spot");
        serve(1'b1, 1'b0, 2'd0, 3, "first_entry");
        serve(1'b1, 1'b0, 2'd0, 0, "fill1");
        serve(1'b1, 1'b0, 2'd0, 2, "fill2");
        serve(1'b0, 1'b1, 2'd1, 1, "empty1");
        chk("F_0101", 32'(F), 32'(4'b0101));
        serve(1'b1, 1'b1, 2'd2, 1, "tie_entry");
        serve(1'b0, 1'b1, 2'd2, 1, "tie_exit");
        chk("F_0011", 32'(F), 32'(4'b0011));
        serve(1'b1, 1'b0, 2'd0, 1, "fill3");
        serve(1'b1, 1'b0, 2'd0, 1, "fill4");
        serve(1'b1, 1'b0, 2'd0, 1, "full_block");
        serve(1'b1, 1'b1, 2'd3, 1, "full_exit3");
        chk("F_0111", 32'(F), 32'(4'b0111));
        serve(1'b1, 1'b0, 2'd0, 1, "pending_entry");
        chk("spot3", 32'(assigned_spot), 32'(2'd3));

        // Reset while the door is open for an exiting car.
        enter_req = 1'b0;
        exit_req  = 1'b1;
        exit_spot = 2'd0;
        #1;
        chk("rst_open:grant_exit", 32'(grant_exit), 32'(1'b1));
        tick();
        exit_req = 1'b0;
        chk("rst_open:door", 32'(door_open), 32'(1'b1));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_f          = 4'b0000;
        m_last_entry = 1'b0;
        chk("rst_open:door_after", 32'(door_open), 32'(1'b0));
        chk_map("rst_open");
        serve(1'b1, 1'b0, 2'd0, 1, "post_rst");

        // Door held open with no car passing.
        spot      = lowest_free(m_f);
        enter_req = 1'b1;
        exit_req  = 1'b0;
        #1;
        chk("hold:grant", 32'(grant_enter), 32'(1'b1));
        tick();
        enter_req    = 1'b0;
        m_last_entry = 1'b1;
`ifdef PARK_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("tmo:door_open", 32'(door_open), 32'(1'b1));
            chk("tmo:no_err", 32'(timeout_err), 32'(1'b0));
            tick();
        end
        chk("tmo:err_pulse", 32'(timeout_err), 32'(1'b1));
        chk("tmo:door_shut", 32'(door_open), 32'(1'b0));
        chk("tmo:F_unchanged", 32'(F), 32'(m_f));
        tick();
        chk("tmo:err_cleared", 32'(timeout_err), 32'(1'b0));
        repeat (CLOSE_CYCLES - 1) tick();
`else
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            chk("hold:door_open", 32'(door_open), 32'(1'b1));
            chk("hold:no_err", 32'(timeout_err), 32'(1'b0));
            tick();
        end
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;
        m_f[spot] = 1'b1;
        chk_map("hold:pass");
        repeat (CLOSE_CYCLES) tick();
`endif

        for (int t = 0; t < 60; t++) begin
            serve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), "rand");
        end
        chk_map("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
